// File: rtl/niosqsys_lcd_tx_fifo.sv
// Avalon-MM slave feeding a first-word fall-through FIFO towards the LCD driver.
// Tracks overflow, keeps the last word the driver consumed, and raises a level irq.
module niosqsys_lcd_tx_fifo #(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned DEPTH  = 8,
   localparam int unsigned AW     = $clog2(DEPTH),
   localparam int unsigned CNT_W  = AW + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              irq
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_last_word;
   logic              r_overflow;
   logic              r_irq_en;

   logic w_wr;
   logic w_empty;
   logic w_full;
   logic w_push_req;
   logic w_push;
   logic w_pop;
   logic w_ctrl;
   logic w_flush;
   logic w_ovf_clr;

   assign w_wr       = chipselect & ~write_n;
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == FULL_CNT);
   assign w_push_req = w_wr && (address == 2'd0);
   assign w_push     = w_push_req & ~w_full;
   assign w_pop      = ~w_empty & out_ready;
   assign w_ctrl     = w_wr && (address == 2'd2);
   assign w_flush    = w_ctrl & writedata[0];
   assign w_ovf_clr  = w_ctrl & writedata[1];

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= writedata[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_last_word <= '0;
         r_overflow  <= 1'b0;
         r_irq_en    <= 1'b0;
      end else begin
         if (w_flush) begin
            // Flush wins over a same-cycle pop, so last_word keeps its value.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
               r_rd_ptr    <= r_rd_ptr + AW'(1);
               r_last_word <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
         if (w_push_req && w_full) r_overflow <= 1'b1;
         else if (w_ovf_clr)       r_overflow <= 1'b0;
         if (w_ctrl) r_irq_en <= writedata[2];
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: readdata[DATA_W-1:0] = r_last_word;
         2'd1: begin
            readdata[CNT_W-1:0] = r_count;
            readdata[16]        = w_empty;
            readdata[17]        = w_full;
            readdata[18]        = r_overflow;
         end
         2'd2:    readdata[2] = r_irq_en;
         default: readdata = '0;
      endcase
   end

   assign out_data  = r_mem[r_rd_ptr];
   assign out_valid = ~w_empty;
   assign irq       = r_irq_en & (w_empty | r_overflow);

endmodule

// File: doc/niosqsys_lcd_tx_fifo.md
NIOSQSYS_LCD_TX_FIFO -- requirements
Module: niosqsys_lcd_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 32, width of each queued LCD word; legal range 1..32.
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, >= 2.
REQ-003 Derived CNT_W = log2(DEPTH)+1, occupancy counter width.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 address  input  2  Avalon-MM register select.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  combinational read data, selected by address.
REQ-011 out_data  output  DATA_W  head-of-FIFO word to LCD driver.
REQ-012 out_valid  output  1  out_data holds a valid entry.
REQ-013 out_ready  input  1  LCD driver accepts the head word.
REQ-014 irq  output  1  level interrupt to CPU.

Function
REQ-015 Write = chipselect & ~write_n; any access with chipselect=0 SHALL have no effect.
REQ-016 Write to address 0 with FIFO not full SHALL push writedata[DATA_W-1:0] at the tail, visible on out_data one cycle later if the FIFO was empty.
REQ-017 Write to address 0 with FIFO full SHALL discard the data and set sticky overflow; full is evaluated at cycle start, so a same-cycle pop does not admit the push.
REQ-018 out_valid SHALL equal ~empty; out_data SHALL show the head entry (first-word fall-through).
REQ-019 Pop occurs when out_valid & out_ready on a rising edge; the head pointer advances and the popped word is copied to register last_word.
REQ-020 Simultaneous accepted push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-021 Read address 0 SHALL return last_word zero-extended to 32 bits.
REQ-022 Read address 1 SHALL return status: [CNT_W-1:0] count, bit16 empty, bit17 full, bit18 overflow, all other bits 0.
REQ-023 Write address 2 SHALL act as control: bit0=1 flush (pointers and count to 0); bit1=1 clear overflow; bit2 stored as irq_en.
REQ-024 Read address 2 SHALL return irq_en at bit2, all other bits 0.
REQ-025 Address 3 SHALL read 0; writes to it ignored.
REQ-026 Flush SHALL take priority over a same-cycle pop; flush does not modify last_word.
REQ-027 Overflow set and clear in the same cycle are impossible (different addresses); overflow SHALL persist through flush until explicitly cleared.
REQ-028 irq SHALL equal irq_en & (empty | overflow), combinational from registered state.
REQ-029 Count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-030 While reset_n=0: pointers, count, overflow, irq_en, last_word = 0; out_valid=0, irq=0, readdata status shows empty=1.
REQ-031 Reset assertion mid-transfer SHALL immediately abandon queued entries; storage array contents need not be reset.
REQ-032 First push after reset release SHALL behave as push into an empty FIFO.

Verification (DATA_W=8, DEPTH=4)
REQ-033 Push 0x11,0x22 with out_ready=0 -> out_valid=1, out_data=0x11, status count=2, empty=0.
REQ-034 Push 0xA1..0xA5 with out_ready=0 -> count=4, full=1, overflow=1, 0xA5 never appears on out_data.
REQ-035 Full FIFO, push 0x77 with out_ready=1 same cycle -> 0x77 dropped, overflow=1, count=3, last_word=0xA1.
REQ-036 Count=2, push 0x33 with out_ready=1 same cycle -> count stays 2, pointers wrap correctly over 10 cycles of continuous streaming.
REQ-037 irq_en=1, drain to empty -> irq=1; write control 0x4|0x2 with overflow set -> overflow=0, irq follows empty only.
REQ-038 Count=3, write control bit0=1 with out_ready=1 -> count=0, out_valid=0 next cycle, last_word unchanged; reset_n pulse mid-stream -> all status zero, empty=1.
